// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction-fetch / data-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } gnt_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data-memory requests onto one single-ported memory.
// Data has priority; fetch wins after STARVE_LIMIT data grants made while it waited.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    // Requesters hold req (and its payload) until their one-cycle ready pulse;
    // memory sees req held with stable payload until its one-cycle ack.
    input  logic                              if_req_i,
    input  logic [31:0]                       if_addr_i32,
    output logic [31:0]                       if_rdata_o32,
    output logic                              if_ready_o,
    output logic                              if_stall_o,
    input  logic                              dm_req_i,
    input  logic                              dm_we_i,
    input  logic [31:0]                       dm_addr_i32,
    input  logic [31:0]                       dm_wdata_i32,
    output logic [31:0]                       dm_rdata_o32,
    output logic                              dm_ready_o,
    output logic                              dm_stall_o,
    output logic                              mem_req_o,
    output logic                              mem_we_o,
    output logic [31:0]                       mem_addr_o32,
    output logic [31:0]                       mem_wdata_o32,
    input  logic [31:0]                       mem_rdata_i32,
    input  logic                              mem_ack_i,
    output state_e                            dbg_state_o,
    output logic [$clog2(STARVE_LIMIT+1)-1:0] dbg_starve_cnt_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_e            state_q, state_d;
    gnt_e              gnt_q, gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_d, mem_we_d;
    logic [31:0]       mem_addr_d, mem_wdata_d;
    logic [31:0]       if_rdata_d, dm_rdata_d;
    logic              dm_wins;

    // Fetch overrides data only once it has watched STARVE_LIMIT data grants go by.
    assign dm_wins = dm_req_i && !((cnt_q == CNT_MAX) && if_req_i);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_o;
        mem_we_d    = mem_we_o;
        mem_addr_d  = mem_addr_o32;
        mem_wdata_d = mem_wdata_o32;
        if_rdata_d  = if_rdata_o32;
        dm_rdata_d  = dm_rdata_o32;

        case (state_q)
            IDLE: begin
                if (dm_wins) begin
                    state_d     = BUSY_DM;
                    gnt_d       = GNT_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we_i;
                    mem_addr_d  = dm_addr_i32;
                    mem_wdata_d = dm_wdata_i32;
                    if (if_req_i && (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (if_req_i) begin
                    state_d     = BUSY_IF;
                    gnt_d       = GNT_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i32;
                    mem_wdata_d = 32'h0;
                    cnt_d       = '0;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ack_i) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == BUSY_IF) begin
                        if_rdata_d = mem_rdata_i32;
                    end else begin
                        dm_rdata_d = mem_rdata_i32;
                    end
                end
            end
            RESP: begin
                // Requests still high here belong to the transaction just finished.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            gnt_q         <= GNT_IF;
            cnt_q         <= '0;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o32  <= 32'h0;
            mem_wdata_o32 <= 32'h0;
            if_rdata_o32  <= 32'h0;
            dm_rdata_o32  <= 32'h0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            cnt_q         <= cnt_d;
            mem_req_o     <= mem_req_d;
            mem_we_o      <= mem_we_d;
            mem_addr_o32  <= mem_addr_d;
            mem_wdata_o32 <= mem_wdata_d;
            if_rdata_o32  <= if_rdata_d;
            dm_rdata_o32  <= dm_rdata_d;
        end
    end

    assign if_ready_o       = (state_q == RESP) && (gnt_q == GNT_IF);
    assign dm_ready_o       = (state_q == RESP) && (gnt_q == GNT_DM);
    assign if_stall_o       = if_req_i & ~if_ready_o;
    assign dm_stall_o       = dm_req_i & ~dm_ready_o;
    assign dbg_state_o      = state_q;
    assign dbg_starve_cnt_o = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a waiting-memory responder, port drivers,
// and a monitor that pops expected grants and read data as the DUT produces them.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic             clk = 1'b0;
    logic             reset_i;
    logic             if_req_i;
    logic [31:0]      if_addr_i32;
    logic [31:0]      if_rdata_o32;
    logic             if_ready_o;
    logic             if_stall_o;
    logic             dm_req_i;
    logic             dm_we_i;
    logic [31:0]      dm_addr_i32;
    logic [31:0]      dm_wdata_i32;
    logic [31:0]      dm_rdata_o32;
    logic             dm_ready_o;
    logic             dm_stall_o;
    logic             mem_req_o;
    logic             mem_we_o;
    logic [31:0]      mem_addr_o32;
    logic [31:0]      mem_wdata_o32;
    logic [31:0]      mem_rdata_i32;
    logic             mem_ack_i;
    state_e           dbg_state_o;
    logic [CNT_W-1:0] dbg_starve_cnt_o;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .if_req_i         (if_req_i),
        .if_addr_i32      (if_addr_i32),
        .if_rdata_o32     (if_rdata_o32),
        .if_ready_o       (if_ready_o),
        .if_stall_o       (if_stall_o),
        .dm_req_i         (dm_req_i),
        .dm_we_i          (dm_we_i),
        .dm_addr_i32      (dm_addr_i32),
        .dm_wdata_i32     (dm_wdata_i32),
        .dm_rdata_o32     (dm_rdata_o32),
        .dm_ready_o       (dm_ready_o),
        .dm_stall_o       (dm_stall_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o32     (mem_addr_o32),
        .mem_wdata_o32    (mem_wdata_o32),
        .mem_rdata_i32    (mem_rdata_i32),
        .mem_ack_i        (mem_ack_i),
        .dbg_state_o      (dbg_state_o),
        .dbg_starve_cnt_o (dbg_starve_cnt_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2008_0005;
        return {~a[15:0], a[15:0]};
    endfunction

    // {is_dm, we, addr, wdata}
    function automatic logic [65:0] txn(input logic is_dm, input logic we,
                                        input logic [31:0] addr, input logic [31:0] wdata);
        return {is_dm, we, addr, wdata};
    endfunction

    logic [65:0] gnt_exp_q[$];
    logic [31:0] if_exp_q[$];
    logic [32:0] dm_exp_q[$];   // {check_data, data}

    // ---------------- memory responder ----------------
    int   ack_wait   = 0;
    logic ack_enable = 1'b1;
    logic force_ack  = 1'b0;
    int   wait_cnt   = 0;

    initial begin
        mem_ack_i     = 1'b0;
        mem_rdata_i32 = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                wait_cnt  = 0;
            end else if (force_ack) begin
                mem_ack_i     = 1'b1;
                mem_rdata_i32 = 32'hBAD0_BAD0;
                force_ack     = 1'b0;
            end else if (mem_req_o && ack_enable) begin
                if (wait_cnt == ack_wait) begin
                    mem_ack_i     = 1'b1;
                    mem_rdata_i32 = model_rd(mem_addr_o32);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [65:0] cur_txn;
    logic        txn_active  = 1'b0;
    logic        rst_in_txn  = 1'b0;
    int          busy_len    = 0;
    int          exp_len     = 0;
    logic        prev_if_rdy = 1'b0;
    logic        prev_dm_rdy = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset_i && txn_active) rst_in_txn = 1'b1;
            check("if_stall", if_stall_o, if_req_i & ~if_ready_o);
            check("dm_stall", dm_stall_o, dm_req_i & ~dm_ready_o);
            if (mem_req_o) begin
                if (!txn_active) begin
                    check("txn_expected", gnt_exp_q.size() != 0, 1);
                    cur_txn    = (gnt_exp_q.size() != 0) ? gnt_exp_q.pop_front() : '0;
                    txn_active = 1'b1;
                    rst_in_txn = 1'b0;
                    busy_len   = 0;
                    exp_len    = ack_wait + 1;
                end
                busy_len++;
                check("mem_addr", mem_addr_o32, cur_txn[63:32]);
                check("mem_we", mem_we_o, cur_txn[64]);
                if (cur_txn[65]) check("mem_wdata", mem_wdata_o32, cur_txn[31:0]);
            end else if (txn_active) begin
                if (!rst_in_txn) check("busy_len", busy_len, exp_len);
                txn_active = 1'b0;
            end
            if (if_ready_o) begin
                check("if_ready_pulse", prev_if_rdy, 0);
                check("if_ready_expected", if_exp_q.size() != 0, 1);
                if (if_exp_q.size() != 0) check("if_rdata", if_rdata_o32, if_exp_q.pop_front());
            end
            if (dm_ready_o) begin
                logic [32:0] e;
                check("dm_ready_pulse", prev_dm_rdy, 0);
                check("dm_ready_expected", dm_exp_q.size() != 0, 1);
                if (dm_exp_q.size() != 0) begin
                    e = dm_exp_q.pop_front();
                    if (e[32]) check("dm_rdata", dm_rdata_o32, e[31:0]);
                end
            end
            prev_if_rdy = if_ready_o;
            prev_dm_rdy = dm_ready_o;
        end
    end

    // ---------------- drivers ----------------
    task automatic do_fetch(input logic [31:0] addr, input int hold_extra, output int lat);
        logic seen;
        if_exp_q.push_back(model_rd(addr));
        if_addr_i32 = addr;
        if_req_i    = 1'b1;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (if_ready_o) seen = 1'b1;
        end
        check("if_done", seen, 1);
        repeat (hold_extra) @(negedge clk);
        if_req_i = 1'b0;
    endtask

    task automatic do_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int hold_extra, output int lat);
        logic seen;
        dm_exp_q.push_back({~we, model_rd(addr)});
        dm_we_i      = we;
        dm_addr_i32  = addr;
        dm_wdata_i32 = wdata;
        dm_req_i     = 1'b1;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (dm_ready_o) seen = 1'b1;
        end
        check("dm_done", seen, 1);
        repeat (hold_extra) @(negedge clk);
        dm_req_i = 1'b0;
    endtask

    // Back-to-back loads with dm_req held high across completions.
    task automatic dm_stream(input int n, input logic [31:0] base);
        logic seen;
        dm_we_i      = 1'b0;
        dm_wdata_i32 = 32'h1111_0000;
        dm_req_i     = 1'b1;
        for (int k = 0; k < n; k++) begin
            dm_addr_i32 = base + 32'(4 * k);
            dm_exp_q.push_back({1'b1, model_rd(base + 32'(4 * k))});
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                if (dm_ready_o) seen = 1'b1;
            end
            check("stream_done", seen, 1);
        end
        dm_req_i = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    int lat_a, lat_b;

    initial begin
        reset_i      = 1'b1;
        if_req_i     = 1'b0;
        if_addr_i32  = 32'h0;
        dm_req_i     = 1'b0;
        dm_we_i      = 1'b0;
        dm_addr_i32  = 32'h0;
        dm_wdata_i32 = 32'h0;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_we", mem_we_o, 0);
        check("rst_mem_addr", mem_addr_o32, 0);
        check("rst_mem_wdata", mem_wdata_o32, 0);
        check("rst_if_rdata", if_rdata_o32, 0);
        check("rst_dm_rdata", dm_rdata_o32, 0);
        check("rst_if_ready", if_ready_o, 0);
        check("rst_dm_ready", dm_ready_o, 0);
        check("rst_state", dbg_state_o, IDLE);
        check("rst_starve", dbg_starve_cnt_o, 0);
        reset_i = 1'b0;
        repeat (2) @(negedge clk);

        // fetch only, zero wait
        ack_wait = 0;
        gnt_exp_q.push_back(txn(1'b0, 1'b0, 32'h0000_0040, 32'h0));
        do_fetch(32'h0000_0040, 0, lat_a);
        check("fetch_latency", lat_a, 2);
        @(negedge clk);
        check("if_rdata_held", if_rdata_o32, 32'h2008_0005);
        repeat (2) @(negedge clk);

        // simultaneous requests: data first, then fetch
        gnt_exp_q.push_back(txn(1'b1, 1'b0, 32'h0000_0100, 32'h5555_AAAA));
        gnt_exp_q.push_back(txn(1'b0, 1'b0, 32'h0000_0044, 32'h0));
        fork
            do_dm(1'b0, 32'h0000_0100, 32'h5555_AAAA, 0, lat_a);
            do_fetch(32'h0000_0044, 0, lat_b);
        join
        check("both_dm_latency", lat_a, 2);
        check("both_if_latency", lat_b, 5);
        check("dm_rdata_held", dm_rdata_o32, model_rd(32'h0000_0100));
        check("both_starve_cleared", dbg_starve_cnt_o, 0);
        repeat (2) @(negedge clk);

        // store with three wait states
        ack_wait = 3;
        gnt_exp_q.push_back(txn(1'b1, 1'b1, 32'h0000_0080, 32'hDEAD_BEEF));
        do_dm(1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 0, lat_a);
        check("store_latency", lat_a, 5);
        ack_wait = 0;
        repeat (2) @(negedge clk);

        // starvation bound: four data grants, then fetch, then data resumes
        for (int k = 0; k < 4; k++)
            gnt_exp_q.push_back(txn(1'b1, 1'b0, 32'h0000_0200 + 32'(4 * k), 32'h1111_0000));
        gnt_exp_q.push_back(txn(1'b0, 1'b0, 32'h0000_0300, 32'h0));
        gnt_exp_q.push_back(txn(1'b1, 1'b0, 32'h0000_0210, 32'h1111_0000));
        gnt_exp_q.push_back(txn(1'b1, 1'b0, 32'h0000_0214, 32'h1111_0000));
        fork
            dm_stream(6, 32'h0000_0200);
            do_fetch(32'h0000_0300, 0, lat_b);
        join
        check("starve_if_latency", lat_b, 14);
        check("starve_cnt_after", dbg_starve_cnt_o, 0);
        repeat (2) @(negedge clk);

        // request held one cycle past ready: no second grant
        gnt_exp_q.push_back(txn(1'b0, 1'b0, 32'h0000_0048, 32'h0));
        do_fetch(32'h0000_0048, 1, lat_a);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_regrant_if", mem_req_o, 0);
        end
        gnt_exp_q.push_back(txn(1'b1, 1'b0, 32'h0000_0120, 32'h0));
        do_dm(1'b0, 32'h0000_0120, 32'h0, 1, lat_a);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_regrant_dm", mem_req_o, 0);
        end

        // reset during BUSY_DM with a late ack
        begin
            logic seen;
            ack_enable = 1'b0;
            gnt_exp_q.push_back(txn(1'b1, 1'b0, 32'h0000_0400, 32'h0));
            if_addr_i32  = 32'h0000_0500;
            dm_addr_i32  = 32'h0000_0400;
            dm_we_i      = 1'b0;
            dm_wdata_i32 = 32'h0;
            if_req_i     = 1'b1;
            dm_req_i     = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (mem_req_o) seen = 1'b1;
            end
            check("midrst_busy_seen", seen, 1);
            check("midrst_state_busy", dbg_state_o, BUSY_DM);
            check("midrst_starve_one", dbg_starve_cnt_o, 1);
            @(negedge clk);
            reset_i  = 1'b1;
            if_req_i = 1'b0;
            dm_req_i = 1'b0;
            @(posedge clk);
            #1;
            force_ack = 1'b1;
            @(negedge clk);
            reset_i = 1'b0;
            check("midrst_req_low", mem_req_o, 0);
            @(negedge clk);
            check("midrst_req_low_ack", mem_req_o, 0);
            check("midrst_state_idle", dbg_state_o, IDLE);
            check("midrst_starve_zero", dbg_starve_cnt_o, 0);
            check("midrst_dm_rdata", dm_rdata_o32, 0);
            for (int i = 0; i < 3; i++) begin
                check("midrst_no_ready", dm_ready_o, 0);
                @(negedge clk);
            end
            ack_enable = 1'b1;
        end

        repeat (2) @(negedge clk);
        check("gnt_q_drained", gnt_exp_q.size(), 0);
        check("if_q_drained", if_exp_q.size(), 0);
        check("dm_q_drained", dm_exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the pipeline's instruction-fetch port and its data-memory (MEM-stage) port. Serialises requests through a small FSM, forwards one transaction at a time to memory, and returns read data with a one-cycle ready pulse. Produces per-port stall signals for the hazard unit. Data accesses have priority, with a bounded-starvation guarantee for fetch.

## Interface
- `STARVE_LIMIT`, default 4: consecutive data grants made while fetch is pending before fetch is forced to win.
- `clk_i` in 1: clock.
- `reset_i` in 1: synchronous, active-high reset.
- `if_req_i` in 1: fetch request, held until `if_ready_o`.
- `if_addr_i32` in 32: fetch address.
- `if_rdata_o32` out 32: fetched instruction; valid when `if_ready_o`, held until next fetch completes.
- `if_ready_o` out 1: one-cycle fetch completion pulse.
- `if_stall_o` out 1: `if_req_i & ~if_ready_o`.
- `dm_req_i` in 1: data request, held until `dm_ready_o`.
- `dm_we_i` in 1: 1 = store, 0 = load.
- `dm_addr_i32` in 32: data address.
- `dm_wdata_i32` in 32: store data.
- `dm_rdata_o32` out 32: load data; valid when `dm_ready_o`, held until next data completion.
- `dm_ready_o` out 1: one-cycle data completion pulse.
- `dm_stall_o` out 1: `dm_req_i & ~dm_ready_o`.
- `mem_req_o` out 1: memory request, held until `mem_ack_i`.
- `mem_we_o` out 1: memory write enable.
- `mem_addr_o32` out 32: memory address.
- `mem_wdata_o32` out 32: memory write data.
- `mem_rdata_i32` in 32: memory read data, valid in the `mem_ack_i` cycle.
- `mem_ack_i` in 1: one-cycle completion from memory.

## Operation
- FSM states: `IDLE`, `BUSY_IF`, `BUSY_DM`, `RESP`.
- **`IDLE` arbitration**:
  - Data wins if `dm_req_i`, unless `starve_cnt == STARVE_LIMIT` and `if_req_i`; then fetch wins.
  - Otherwise fetch wins if `if_req_i`.
  - With no request, stay in `IDLE`.
- **On grant**:
  - Register `mem_req_o`=1, `mem_addr_o32`, `mem_we_o` (`dm_we_i` for data, 0 for fetch) and `mem_wdata_o32`.
  - Enter `BUSY_DM` or `BUSY_IF`.
- **`starve_cnt`** (width $clog2(STARVE_LIMIT+1)):
  - Increments on a data grant while `if_req_i`=1.
  - Clears on any fetch grant.
  - Saturates at `STARVE_LIMIT`.
- **`BUSY_*`**:
  - Hold all `mem_*` outputs stable until `mem_ack_i`.
  - On ack, capture `mem_rdata_i32` into the granted port's rdata register (also on stores; the value is don't-care).
  - Drop `mem_req_o` and `mem_we_o`, go to `RESP`.
- **`RESP`**:
  - Pulse the granted port's ready for exactly one cycle, then return to `IDLE`.
  - Requests are ignored in `RESP`, so a requester dropping or changing its request after ready is never double-granted.
- **Ignored inputs**: `mem_ack_i` in `IDLE`/`RESP`; request changes during `BUSY_*` (protocol violation, no effect on the current transaction).
- **Addresses** pass through unmodified; no alignment checks.

## Timing
- Reset: state `IDLE`, `starve_cnt`=0, and every output 0 (`mem_req_o`, `mem_we_o`, `mem_addr_o32`, `mem_wdata_o32`, both rdata registers, both ready pulses). Stalls then follow their requests combinationally.
- Reset mid-transaction: `mem_req_o` is low the cycle after reset; a late `mem_ack_i` is ignored.
- Request sampled in `IDLE` at cycle T:
  - `mem_req_o` high T+1.
  - Ack at T+1+k (k≥0).
  - Ready and rdata valid at T+2+k.
  - `IDLE` at T+3+k.
- Minimum occupancy is 3 cycles per transaction; back-to-back throughput is one transaction per (3+k) cycles.
- Stall outputs are combinational and drop in the ready cycle.

## Structure
- `mem_arb_pkg`: state enum (`IDLE`, `BUSY_IF`, `BUSY_DM`, `RESP`) and grant enum (`GNT_IF`, `GNT_DM`).
- Single module; no sub-module. Register banks may use the codebase's existing `flopr`/`flopenr` primitives.

## Test plan
- Fetch only, addr 0x0000_0040, ack after 0 wait, rdata 0x2008_0005 → `mem_req_o` at T+1, `if_ready_o` pulse at T+2 with `if_rdata_o32`=0x2008_0005.
- Both ports request in the same cycle: data load 0x100 and fetch 0x44 → data is served first, then fetch; `dm_ready_o` precedes `if_ready_o`; `if_stall_o` stays high throughout.
- Store to 0x80 with wdata 0xDEAD_BEEF, ack after 3 waits → `mem_we_o`=1 with stable addr/wdata for 4 cycles; `dm_ready_o` pulses once; `dm_rdata_o32` is not checked.
- Continuous data requests plus a held fetch, `STARVE_LIMIT`=4 → exactly 4 data grants, then 1 fetch grant, then data resumes.
- Reset asserted during `BUSY_DM`, with ack arriving the cycle after reset → `mem_req_o`=0, no ready pulse, FSM in `IDLE`, `starve_cnt`=0.
- Requester holds request one extra cycle after ready → no second grant issued from `RESP`.
